// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters: A (ALU/execute result) and B (load/memory response).
//   A grant is decided every cycle and drives the select of the external
//   2:1 writeback mux. The mux output and the winner's destination register
//   are captured into a one-cycle output register that feeds the regfile
//   write port. Cycles in which both requesters collide are counted in a
//   saturating counter for performance tuning.
//
// Parameters:
//   N      data width of writeback values / mux output
//   AW     register address width
//   CNT_W  width of the collision counter
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active-low
//   a_valid      in   1      requester A has a writeback
//   a_rd         in   AW     A destination register
//   a_ready      out  1      A granted this cycle (combinational)
//   b_valid      in   1      requester B has a writeback
//   b_rd         in   AW     B destination register
//   b_ready      out  1      B granted this cycle (combinational)
//   stall        in   1      pipeline freeze, no grants while high
//   wb_sel       out  1      mux select, 0 = A data, 1 = B data
//   wb_mux_y     in   N      external mux output (granted requester data)
//   rf_we        out  1      regfile write enable (registered)
//   rf_waddr     out  AW     regfile write address (registered)
//   rf_wdata     out  N      regfile write data (registered)
//   collide_cnt  out  CNT_W  saturating count of collision cycles
//
// Configuration:
//   WB_FIXED_PRIO_EN  when defined, B always wins a collision and the
//                     round-robin priority register is removed. A can
//                     starve under continuous B traffic. When undefined,
//                     collisions alternate round-robin.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int N     = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_rd,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_rd,
  output logic             b_ready,
  input  logic             stall,
  output logic             wb_sel,
  input  logic [N-1:0]     wb_mux_y,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [N-1:0]     rf_wdata,
  output logic [CNT_W-1:0] collide_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic          prio_b;
  logic          grant_a;
  logic          grant_b;
  logic          fire;
  logic          collide;
  logic [AW-1:0] win_rd;

`ifdef WB_FIXED_PRIO_EN
  // Loads always win a collision, so there is no priority state at all.
  assign prio_b = 1'b1;
`else
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t prio;

  // Round-robin pointer: after every transfer the requester that was not
  // served gets first claim on the next collision. It only moves on a
  // transfer, so stalls and idle cycles leave the order untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= PRIO_A;
    end else if (fire) begin
      prio <= grant_a ? PRIO_B : PRIO_A;
    end
  end

  assign prio_b = (prio == PRIO_B);
`endif

  // Grant decision. Readies depend only on valids, stall, reset and the
  // priority state, never on each other, so no combinational loop can form
  // through a requester. Reset is folded in so nobody handshakes while the
  // block is being reset.
  always_comb begin
    grant_a = rst_n & ~stall & a_valid & (~b_valid | ~prio_b);
    grant_b = rst_n & ~stall & b_valid & (~a_valid | prio_b);
    fire    = grant_a | grant_b;
    win_rd  = grant_b ? b_rd : a_rd;
    collide = a_valid & b_valid & ~stall;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign wb_sel  = grant_b;

  // Output register toward the regfile write port. The write enable lasts
  // exactly one cycle per transfer, and writes aimed at x0 complete the
  // handshake without ever enabling the port. Address and data are loaded
  // on every transfer (including x0) and held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= fire && (win_rd != '0);
      if (fire) begin
        rf_waddr <= win_rd;
        rf_wdata <= wb_mux_y;
      end
    end
  end

  // Collision counter. Counts every unstalled cycle in which both
  // requesters are valid, and sticks at all-ones instead of wrapping so a
  // long run never reads back as a small number.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collide_cnt <= '0;
    end else if (collide && (collide_cnt != CNT_MAX)) begin
      collide_cnt <= collide_cnt + 1'b1;
    end
  end

endmodule
